// File: rtl/simon_autoplayer_if.sv
// Game-side signal bundle between the Simon autoplayer (master) and the game core / bench (slave).
interface simon_autoplayer_if;
   logic [15:0] ticks_per_milli;
   logic        enable;
   logic [3:0]  led;
   logic [3:0]  btn;
   logic [5:0]  level;
   logic        game_over;
   logic        overflow;
   logic        busy;

   modport master (
      input  ticks_per_milli, enable, led,
      output btn, level, game_over, overflow, busy
   );

   modport slave (
      output ticks_per_milli, enable, led,
      input  btn, level, game_over, overflow, busy
   );
endinterface

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the LED playback sequence, then replays it on the buttons each round.
module simon_autoplayer #(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned PRESS_MS = 50,
   parameter int unsigned GAP_MS   = 200,
   parameter int unsigned INTER_MS = 200
) (
   input logic                 clk,
   input logic                 rst_n,
   simon_autoplayer_if.master  game_io
);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MS_W   = 16;
   localparam int unsigned TICK_W = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LISTEN, S_PRESS, S_ECHO, S_INTER, S_HALT
   } state_e;

   state_e             state_q, state_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic [3:0]         led_q;
   logic [CNT_W-1:0]   rec_cnt_q, rec_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [5:0]         level_q, level_d;
   logic               game_over_q, game_over_d;
   logic               overflow_q, overflow_d;
   logic               seen_q, seen_d;
   logic [3:0]         btn_q, btn_d;
   logic               busy_q, busy_d;
   logic [1:0]         mem_q [DEPTH];
   logic               mem_we_c;
   logic [1:0]         code_c;
   logic               onset_c, all_on_c, tick_hit_c, ms_clr_c;

   assign all_on_c   = (game_io.led == 4'b1111);
   assign onset_c    = (led_q == 4'b0000) && $onehot(game_io.led);
   assign tick_hit_c = (tick_q == game_io.ticks_per_milli);

   always_comb begin
      code_c = 2'd0;
      if (game_io.led[1])      code_c = 2'd1;
      else if (game_io.led[2]) code_c = 2'd2;
      else if (game_io.led[3]) code_c = 2'd3;
   end

   // Next-state, bookkeeping and registered-output decisions
   always_comb begin
      state_d     = state_q;
      rec_cnt_d   = rec_cnt_q;
      idx_d       = idx_q;
      level_d     = level_q;
      game_over_d = game_over_q;
      overflow_d  = overflow_q;
      seen_d      = seen_q;
      mem_we_c    = 1'b0;
      btn_d       = 4'b0000;
      busy_d      = 1'b0;
      ms_clr_c    = 1'b0;

      if (!game_io.enable) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               game_over_d = 1'b0;
               overflow_d  = 1'b0;
               rec_cnt_d   = '0;
               state_d     = all_on_c ? S_START : S_LISTEN;
            end
            S_START: begin
               if (ms_q == MS_W'(PRESS_MS)) begin
                  rec_cnt_d = '0;
                  state_d   = S_LISTEN;
               end
            end
            S_LISTEN: begin
               if (all_on_c) begin
                  game_over_d = 1'b1;
                  state_d     = S_HALT;
               end else if (onset_c) begin
                  if (rec_cnt_q == CNT_W'(DEPTH)) begin
                     overflow_d = 1'b1;
                     state_d    = S_HALT;
                  end else begin
                     mem_we_c  = 1'b1;
                     rec_cnt_d = rec_cnt_q + CNT_W'(1);
                  end
               end else if ((rec_cnt_q != '0) && (game_io.led == 4'b0000) &&
                            (ms_q == MS_W'(GAP_MS))) begin
                  level_d = 6'(rec_cnt_q);
                  idx_d   = '0;
                  state_d = S_PRESS;
               end
            end
            S_PRESS: begin
               if (ms_q == MS_W'(PRESS_MS)) begin
                  seen_d  = 1'b0;
                  state_d = S_ECHO;
               end
            end
            S_ECHO: begin
               if (all_on_c) begin
                  game_over_d = 1'b1;
                  state_d     = S_HALT;
               end else if (game_io.led != 4'b0000) begin
                  seen_d = 1'b1;
               end else if (seen_q) begin
                  state_d = S_INTER;
               end
            end
            S_INTER: begin
               if (all_on_c) begin
                  game_over_d = 1'b1;
                  state_d     = S_HALT;
               end else if (ms_q == MS_W'(INTER_MS)) begin
                  if (6'(idx_q) + 6'd1 == level_q) begin
                     rec_cnt_d = '0;
                     state_d   = S_LISTEN;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = S_PRESS;
                  end
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Gap timer restarts on any LED activity while listening
      ms_clr_c = (state_d != state_q) ||
                 ((state_q == S_LISTEN) && (game_io.led != 4'b0000));

      // btn follows the decided next state so it switches on the transition edge
      unique case (state_d)
         S_START: btn_d = 4'b0001;
         S_PRESS: btn_d = 4'b0001 << mem_q[idx_d];
         default: btn_d = 4'b0000;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   always_comb begin
      tick_d = tick_hit_c ? '0 : tick_q + TICK_W'(1);
      if (ms_clr_c)        ms_d = '0;
      else if (tick_hit_c) ms_d = ms_q + MS_W'(1);
      else                 ms_d = ms_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         ms_q        <= '0;
         led_q       <= 4'b0000;
         rec_cnt_q   <= '0;
         idx_q       <= '0;
         level_q     <= 6'd0;
         game_over_q <= 1'b0;
         overflow_q  <= 1'b0;
         seen_q      <= 1'b0;
         btn_q       <= 4'b0000;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         ms_q        <= ms_d;
         led_q       <= game_io.led;
         rec_cnt_q   <= rec_cnt_d;
         idx_q       <= idx_d;
         level_q     <= level_d;
         game_over_q <= game_over_d;
         overflow_q  <= overflow_d;
         seen_q      <= seen_d;
         btn_q       <= btn_d;
         busy_q      <= busy_d;
      end
   end

   // Sequence memory has no reset; entries are written before they are replayed
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[rec_cnt_q[IDX_W-1:0]] <= code_c;
   end

   assign game_io.btn       = btn_q;
   assign game_io.level     = level_q;
   assign game_io.game_over = game_over_q;
   assign game_io.overflow  = overflow_q;
   assign game_io.busy      = busy_q;
endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: start press, record/replay rounds, loss, overflow, enable drop, reset.
module tb_simon_autoplayer;
   localparam int CLK_PER_MS = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   simon_autoplayer_if gio();

   simon_autoplayer #(
      .DEPTH(4), .PRESS_MS(50), .GAP_MS(200), .INTER_MS(200)
   ) dut (
      .clk(clk), .rst_n(rst_n), .game_io(gio)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              led_n;
      logic [3:0][3:0] led_seq;
      int              exp_n;
      logic [3:0][3:0] exp_btn;
      logic [5:0]      exp_level;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_btn(input int budget, output int cyc, output logic ok);
      cyc = 0;
      ok  = 1'b1;
      while (gio.btn == 4'b0000) begin
         if (cyc >= budget) begin
            ok = 1'b0;
            break;
         end
         tick();
         cyc++;
      end
   endtask

   // Count cycles btn stays high from the cycle it was first seen
   task automatic press_len(output int plen);
      plen = 1;
      while (gio.btn != 4'b0000 && plen < 400) begin
         tick();
         if (gio.btn != 4'b0000) plen++;
      end
   endtask

   task automatic play_leds(input vec_t v);
      for (int j = 0; j < v.led_n; j++) begin
         gio.led = v.led_seq[j];
         repeat (300 * CLK_PER_MS) tick();
         gio.led = 4'b0000;
         repeat (100 * CLK_PER_MS) tick();
      end
   endtask

   // Echo each press for 300 ms like the game does, checking order, length and spacing
   task automatic replay(input vec_t v);
      int   cyc, plen, gap;
      logic ok;
      gap = 0;
      for (int k = 0; k < v.exp_n; k++) begin
         wait_btn(10000, cyc, ok);
         check("press_seen", 32'(ok), 32'd1);
         if (!ok) return;
         gap += cyc;
         if (k == 0) check("level", 32'(gio.level), 32'(v.exp_level));
         else        check_range("inter_gap", gap, 200 * CLK_PER_MS, 100000);
         check("btn_code", 32'(gio.btn), 32'(v.exp_btn[k]));
         gio.led = gio.btn;
         press_len(plen);
         check_range("press_len", plen, 245, 255);
         repeat (300 * CLK_PER_MS - plen) tick();
         gio.led = 4'b0000;
         gap = 300 * CLK_PER_MS - plen;
      end
      repeat (250 * CLK_PER_MS) tick();
      check("relisten_btn", 32'(gio.btn), 32'd0);
      check("relisten_busy", 32'(gio.busy), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc, plen;
      logic ok;

      vecs[0] = '{3, {4'h0, 4'h8, 4'h1, 4'h4}, 3, {4'h0, 4'h8, 4'h1, 4'h4}, 6'd3};
      vecs[1] = '{3, {4'h0, 4'h8, 4'h6, 4'h2}, 2, {4'h0, 4'h0, 4'h8, 4'h2}, 6'd2};
      vecs[2] = '{1, {4'h0, 4'h0, 4'h0, 4'h1}, 1, {4'h0, 4'h0, 4'h0, 4'h1}, 6'd1};
      vecs[3] = '{4, {4'h1, 4'h2, 4'h4, 4'h8}, 4, {4'h1, 4'h2, 4'h4, 4'h8}, 6'd4};

      gio.ticks_per_milli = 16'd4;
      gio.enable          = 1'b0;
      gio.led             = 4'b0000;
      repeat (3) tick();
      check("rst_btn", 32'(gio.btn), 32'd0);
      check("rst_level", 32'(gio.level), 32'd0);
      check("rst_game_over", 32'(gio.game_over), 32'd0);
      check("rst_overflow", 32'(gio.overflow), 32'd0);
      check("rst_busy", 32'(gio.busy), 32'd0);

      // Asynchronous reset in the middle of the start press
      rst_n = 1'b1;
      tick();
      gio.enable = 1'b1;
      gio.led    = 4'b1111;
      tick();
      gio.led = 4'b0000;
      repeat (50) tick();
      check("start_btn_pre_rst", 32'(gio.btn), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_btn", 32'(gio.btn), 32'd0);
      check("async_rst_busy", 32'(gio.busy), 32'd0);
      gio.enable = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Start press
      gio.enable = 1'b1;
      gio.led    = 4'b1111;
      wait_btn(20, cyc, ok);
      check("start_seen", 32'(ok), 32'd1);
      gio.led = 4'b0000;
      check("start_btn", 32'(gio.btn), 32'd1);
      check("start_busy", 32'(gio.busy), 32'd1);
      press_len(plen);
      check_range("start_len", plen, 245, 255);
      repeat (2) tick();
      check("listen_btn", 32'(gio.btn), 32'd0);
      check("listen_busy", 32'(gio.busy), 32'd1);

      for (int i = 0; i < 4; i++) begin
         play_leds(vecs[i]);
         replay(vecs[i]);
      end
      check("no_game_over", 32'(gio.game_over), 32'd0);
      check("no_overflow", 32'(gio.overflow), 32'd0);

      // Loss during INTER
      gio.led = 4'b0010;
      repeat (300 * CLK_PER_MS) tick();
      gio.led = 4'b0000;
      wait_btn(10000, cyc, ok);
      check("loss_press_seen", 32'(ok), 32'd1);
      check("loss_btn", 32'(gio.btn), 32'd2);
      gio.led = gio.btn;
      repeat (300 * CLK_PER_MS) tick();
      gio.led = 4'b0000;
      repeat (50 * CLK_PER_MS) tick();
      gio.led = 4'b1111;
      repeat (2) tick();
      check("loss_game_over", 32'(gio.game_over), 32'd1);
      check("loss_btn_zero", 32'(gio.btn), 32'd0);
      check("loss_busy", 32'(gio.busy), 32'd0);
      gio.led = 4'b0000;
      repeat (300 * CLK_PER_MS) tick();
      check("halt_btn", 32'(gio.btn), 32'd0);
      check("halt_game_over_held", 32'(gio.game_over), 32'd1);
      gio.enable = 1'b0;
      repeat (2) tick();
      check("idle_busy", 32'(gio.busy), 32'd0);
      check("idle_game_over_held", 32'(gio.game_over), 32'd1);
      gio.enable = 1'b1;
      repeat (2) tick();
      check("rejoin_game_over_clr", 32'(gio.game_over), 32'd0);
      check("rejoin_busy", 32'(gio.busy), 32'd1);

      // Overflow: DEPTH onsets fit, the next one overflows
      for (int i = 0; i < 5; i++) begin
         gio.led = 4'b0001 << (i % 4);
         repeat (5) tick();
         gio.led = 4'b0000;
         repeat (5) tick();
         if (i == 3) begin
            check("ovf_at_depth", 32'(gio.overflow), 32'd0);
            check("ovf_at_depth_busy", 32'(gio.busy), 32'd1);
         end
      end
      check("ovf_flag", 32'(gio.overflow), 32'd1);
      check("ovf_busy", 32'(gio.busy), 32'd0);
      check("ovf_btn", 32'(gio.btn), 32'd0);

      // Enable dropped mid-press releases btn on the next edge
      gio.enable = 1'b0;
      repeat (2) tick();
      gio.enable = 1'b1;
      gio.led    = 4'b1111;
      tick();
      gio.led = 4'b0000;
      repeat (20) tick();
      check("restart_btn", 32'(gio.btn), 32'd1);
      check("restart_ovf_clr", 32'(gio.overflow), 32'd0);
      gio.enable = 1'b0;
      tick();
      check("drop_btn", 32'(gio.btn), 32'd0);
      check("drop_busy", 32'(gio.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
